// File: rtl/inv_restore_17_serial.sv
// ---------------------------------------------------------------------------
// inv_restore_17_serial
//
// Purpose:
//   Bit-serial two's-complement negation of a 17-bit operand. One operand is
//   accepted at a time. It is negated LSB first, one bit per clock. The
//   16-bit truncated result is presented together with an overflow flag. The
//   flag is set when the negated value cannot be represented in 16-bit two's
//   complement.
//
//   Negation uses the classic "copy through the first 1, invert everything
//   above it" rule. This needs no adder. The only state carried between bits
//   is a single seen_one flag.
//
// Ports:
//   sys_clk    in   1   clock; all state changes on the rising edge
//   sys_rst_n  in   1   asynchronous active-low reset
//   in_valid   in   1   data_i carries an operand
//   in_ready   out  1   block is idle and will take an operand this cycle
//   data_i     in   17  two's-complement operand
//   out_valid  out  1   data_o / ovf_o carry a result
//   out_ready  in   1   consumer takes the result this cycle
//   data_o     out  16  low 16 bits of -operand
//   ovf_o      out  1   -operand does not fit in 16-bit two's complement
// ---------------------------------------------------------------------------
module inv_restore_17_serial (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] data_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] data_o,
  output logic        ovf_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Index of the last operand bit; the SHIFT state ends after this bit.
  localparam logic [4:0] LastBit = 5'd16;

  state_t      state_q;
  logic [16:0] shift_q;
  logic [16:0] shift_d;
  logic [16:0] res_q;
  logic [16:0] res_d;
  logic [4:0]  cnt_q;
  logic        seen_q;
  logic        seen_d;
  logic        res_bit;

  logic        in_ready_q;
  logic        out_valid_q;
  logic [15:0] data_q;
  logic        ovf_q;

  // One serial step. The operand bit is copied until a 1 has been seen, and
  // inverted after that. The 1 bit itself is still copied, because seen_one
  // only updates after the bit is used. The operand shifts out to the right.
  // Each result bit enters at the top of res, so after 17 steps bit 0 of the
  // result has reached res[0].
  always_comb begin
    res_bit = shift_q[0] ^ seen_q;
    seen_d  = seen_q | shift_q[0];
    shift_d = {1'b0, shift_q[16:1]};
    res_d   = {res_bit, res_q[16:1]};
  end

  // Control FSM and datapath registers. The handshake and result outputs are
  // registered alongside the state. They change only on the edges that move
  // the FSM, so data_o/ovf_o hold steady during backpressure. They read as
  // zero everywhere outside DONE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_q    <= data_i;
            res_q      <= '0;
            cnt_q      <= '0;
            seen_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end

        SHIFT: begin
          shift_q <= shift_d;
          res_q   <= res_d;
          seen_q  <= seen_d;
          cnt_q   <= cnt_q + 5'd1;
          // The final step publishes the result taken from res_d. This lets
          // out_valid rise on the same edge that consumes bit 16.
          if (cnt_q == LastBit) begin
            out_valid_q <= 1'b1;
            data_q      <= res_d[15:0];
            ovf_q       <= res_d[16] ^ res_d[15];
            state_q     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          data_q      <= '0;
          ovf_q       <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_o    = data_q;
  assign ovf_o     = ovf_q;

endmodule

// File: doc/inv_restore_17_serial.md
INV_RESTORE_17_SERIAL -- requirements
Module: inv_restore_17_serial

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 17-bit input and 16-bit result.
REQ-002 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 sys_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 in_valid  input  1  data_i holds a valid 17-bit two's-complement operand.
REQ-005 in_ready  output  1  block can accept an operand this cycle.
REQ-006 data_i  input  17  two's-complement operand to be negated.
REQ-007 out_valid  output  1  data_o/ovf_o hold a valid result.
REQ-008 out_ready  input  1  consumer accepts the result this cycle.
REQ-009 data_o  output  16  low 16 bits of the two's-complement negation of the operand.
REQ-010 ovf_o  output  1  negation does not fit in 16-bit two's complement.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 Accept rule: in IDLE with in_valid=1, the block SHALL register data_i into a 17-bit shift register, clear a 5-bit bit counter and a seen_one flag, and enter SHIFT.
REQ-014 Bit-serial negation, LSB first, one bit per cycle in SHIFT: result bit = operand bit when seen_one=0, else its inverse; seen_one is then set to seen_one OR operand bit.
REQ-015 This "copy through first 1, invert above it" rule SHALL produce (-operand) mod 2^17 in a 17-bit result register r.
REQ-016 SHIFT SHALL last exactly 17 cycles (counter 0..16); the edge that processes bit 16 SHALL move the FSM to DONE.
REQ-017 Latency: if the accept happens at edge E, out_valid SHALL first be 1 immediately after edge E+17.
REQ-018 In DONE, data_o SHALL equal r[15:0] and ovf_o SHALL equal r[16] XOR r[15].
REQ-019 data_o and ovf_o SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge; there is no same-cycle accept of a new operand.
REQ-021 Changes on data_i or in_valid during SHIFT or DONE SHALL be ignored.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 Peak throughput SHALL be one operand per 19 cycles: 1 IDLE, 17 SHIFT, 1 DONE.
REQ-024 data_o and ovf_o SHALL be 0 whenever the FSM is not in DONE.

Reset
REQ-025 While sys_rst_n=0, the block SHALL hold state IDLE, counter 0, seen_one 0, shift register 0, result register 0.
REQ-026 Output values during reset SHALL be: in_ready=1, out_valid=0, data_o=16'h0000, ovf_o=0.
REQ-027 Reset asserted during SHIFT or DONE SHALL abort the operation with no result emitted.
REQ-028 After deassertion, the first accept SHALL be possible on the next rising edge with in_valid=1.

Verification
REQ-029 data_i=17'h08000 (+32768) -> 17 cycles after accept: data_o=16'h8000, ovf_o=0.
REQ-030 data_i=17'h18000 (-32768) -> data_o=16'h8000, ovf_o=1. data_i=17'h0FFFF (+65535) -> data_o=16'h0001, ovf_o=1.
REQ-031 data_i=17'h00000 -> data_o=16'h0000, ovf_o=0. data_i=17'h00001 -> data_o=16'hFFFF, ovf_o=0. data_i=17'h10000 -> data_o=16'h0000, ovf_o=1.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout, then IDLE one edge after out_ready=1.
REQ-033 Reset pulse at SHIFT cycle 8 -> out_valid never asserts for that operand; the next operand completes with correct value and exact latency of 17 cycles.
REQ-034 Random back-to-back operands with random in_valid/out_ready -> every result matches a -x reference model, and the inter-accept spacing is at least 19 cycles.
